isp_stream_sched: RTL and testbench

- Frame-synchronous output scheduler for the ISP chain.
- Takes four candidate pixel streams: camera RGB565 bypass, Y grey, Sobel binary, and morphology (erosion/dilation) result. Forwards exactly one of them to the SDRAM write path.
- Mode changes are requested at any time but take effect only on frame boundaries, so downstream never receives a torn frame.
- Sits between the ISP stages and the FIFO/SDRAM writer, in place of a hard-wired isp_wr_en/isp_rgb565 connection.

---
 rtl/isp_sched_pkg.sv | 18 +
 rtl/isp_pix_cnt.sv | 24 ++
 rtl/isp_stream_sched.sv | 136 +++++++++++++
 tb/tb_isp_stream_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/isp_sched_pkg.sv
// Shared encodings and helpers for the ISP output stream scheduler.
package isp_sched_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GREY   = 2'd1;
  localparam logic [1:0] MODE_SOBEL  = 2'd2;
  localparam logic [1:0] MODE_MORPH  = 2'd3;

  localparam logic [1:0] ST_ALIGN = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PEND  = 2'd2;

  // Replicate luma MSBs into each RGB565 channel.
  function automatic logic [15:0] gray_to_rgb565(input logic [7:0] y);
    return {y[7:3], y[7:2], y[7:3]};
  endfunction

endpackage

// File: rtl/isp_pix_cnt.sv
// Modulo-frame pixel position counter with synchronous resync clear.
module isp_pix_cnt #(
  parameter int unsigned        CNT_W    = 19,
  parameter logic [CNT_W-1:0]   LAST_IDX = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // A pixel coinciding with clear is pixel 0, so the counter lands on 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/isp_stream_sched.sv
// Frame-synchronous selector forwarding one of four ISP streams to the SDRAM
// write path; mode changes only take effect on frame boundaries.
module isp_stream_sched
  import isp_sched_pkg::*;
#(
  parameter int unsigned H_PIX        = 640,
  parameter int unsigned V_PIX        = 480,
  parameter logic [1:0]  DEFAULT_MODE = 2'd3,
  parameter int unsigned CNT_W        = 19
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        mode_req_valid,
  input  logic [1:0]  mode_req,
  input  logic        s0_wr_en,
  input  logic [15:0] s0_data,
  input  logic        s1_wr_en,
  input  logic [7:0]  s1_y,
  input  logic        s2_wr_en,
  input  logic [15:0] s2_data,
  input  logic        s3_wr_en,
  input  logic [15:0] s3_data,
  output logic        isp_wr_en,
  output logic [15:0] isp_rgb565,
  output logic [1:0]  cur_mode,
  output logic        switch_busy,
  output logic        frame_done
);

  localparam int unsigned      FRAME_PIX = H_PIX * V_PIX;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIX - 1);

  logic [3:0]       wr_vec;
  logic [CNT_W-1:0] cnt [4];

  assign wr_vec = {s3_wr_en, s2_wr_en, s1_wr_en, s0_wr_en};

  for (genvar k = 0; k < 4; k++) begin : g_cnt
    isp_pix_cnt #(
      .CNT_W    (CNT_W),
      .LAST_IDX (LAST_IDX)
    ) u_cnt (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clear (frame_start),
      .inc   (wr_vec[k]),
      .cnt   (cnt[k])
    );
  end

  logic        sel_we;
  logic        is_first;
  logic        is_last;
  logic [15:0] sel_pix;

  // frame_start redefines the current pixel as index 0, masking any last.
  always_comb begin
    sel_we   = wr_vec[cur_mode];
    is_first = sel_we && (frame_start || (cnt[cur_mode] == '0));
    is_last  = sel_we && !frame_start && (cnt[cur_mode] == LAST_IDX);
    case (cur_mode)
      MODE_BYPASS: sel_pix = s0_data;
      MODE_GREY:   sel_pix = gray_to_rgb565(s1_y);
      MODE_SOBEL:  sel_pix = s2_data;
      default:     sel_pix = s3_data;
    endcase
  end

  logic [1:0] state, state_nxt;
  logic [1:0] pend_mode, pend_nxt;
  logic [1:0] mode_nxt;
  logic       fwd;
  logic       done_nxt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_ALIGN;
      cur_mode    <= DEFAULT_MODE;
      pend_mode   <= DEFAULT_MODE;
      isp_wr_en   <= 1'b0;
      isp_rgb565  <= '0;
      frame_done  <= 1'b0;
      switch_busy <= 1'b1;
    end else begin
      state       <= state_nxt;
      cur_mode    <= mode_nxt;
      pend_mode   <= pend_nxt;
      isp_wr_en   <= fwd;
      frame_done  <= done_nxt;
      switch_busy <= (state_nxt != ST_RUN);
      if (fwd) isp_rgb565 <= sel_pix;
    end
  end

  // Requests in ALIGN retarget immediately and win over a coincident first pixel.
  always_comb begin
    state_nxt = state;
    mode_nxt  = cur_mode;
    pend_nxt  = pend_mode;
    fwd       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_ALIGN: begin
        if (mode_req_valid) begin
          mode_nxt = mode_req;
          pend_nxt = mode_req;
        end else if (is_first) begin
          fwd       = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        fwd      = sel_we;
        done_nxt = is_last;
        if (mode_req_valid && (mode_req != cur_mode)) begin
          pend_nxt  = mode_req;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        fwd      = sel_we;
        done_nxt = is_last;
        if (mode_req_valid) pend_nxt = mode_req;
        if (mode_req_valid && (mode_req == cur_mode)) begin
          state_nxt = ST_RUN;
        end else if (is_last) begin
          mode_nxt  = pend_nxt;
          state_nxt = ST_ALIGN;
        end
      end
      default: state_nxt = ST_ALIGN;
    endcase
  end

endmodule

// File: tb/tb_isp_stream_sched.sv
// Directed scoreboard bench for isp_stream_sched on a 4x2 frame.
module tb_isp_stream_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        frame_start;
  logic        mode_req_valid;
  logic [1:0]  mode_req;
  logic        s0_wr_en, s1_wr_en, s2_wr_en, s3_wr_en;
  logic [15:0] s0_data, s2_data, s3_data;
  logic [7:0]  s1_y;
  logic        isp_wr_en;
  logic [15:0] isp_rgb565;
  logic [1:0]  cur_mode;
  logic        switch_busy;
  logic        frame_done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] sb[$];

  always #5 sys_clk = ~sys_clk;

  isp_stream_sched #(
    .H_PIX(4), .V_PIX(2), .DEFAULT_MODE(2'd3), .CNT_W(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .mode_req_valid(mode_req_valid), .mode_req(mode_req),
    .s0_wr_en(s0_wr_en), .s0_data(s0_data), .s1_wr_en(s1_wr_en), .s1_y(s1_y),
    .s2_wr_en(s2_wr_en), .s2_data(s2_data), .s3_wr_en(s3_wr_en), .s3_data(s3_data),
    .isp_wr_en(isp_wr_en), .isp_rgb565(isp_rgb565), .cur_mode(cur_mode),
    .switch_busy(switch_busy), .frame_done(frame_done)
  );

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (isp_wr_en) begin
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_out: got pixel %h, expected no output", isp_rgb565);
        end
        if (sb.size() != 0) begin
          logic [16:0] e;
          e = sb.pop_front();
          n_vec++;
          assert (isp_rgb565 === e[15:0]) else begin
            n_err++;
            $error("FAIL pixel: got %h expected %h", isp_rgb565, e[15:0]);
          end
          n_vec++;
          assert (frame_done === e[16]) else begin
            n_err++;
            $error("FAIL frame_done: got %b expected %b", frame_done, e[16]);
          end
        end
      end else begin
        n_vec++;
        assert (frame_done === 1'b0) else begin
          n_err++;
          $error("FAIL stray_done: got %b expected 0", frame_done);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One input cycle; optionally records the expected forwarded pixel.
  task automatic step(input logic [3:0] we, input logic [15:0] d, input logic fs,
                      input logic rv, input logic [1:0] rm,
                      input logic fwd, input logic [15:0] exp, input logic done);
    {s3_wr_en, s2_wr_en, s1_wr_en, s0_wr_en} = we;
    s0_data = d; s2_data = d; s3_data = d; s1_y = d[7:0];
    frame_start = fs; mode_req_valid = rv; mode_req = rm;
    if (fwd) sb.push_back({done, exp});
    @(posedge sys_clk); #1;
    {s3_wr_en, s2_wr_en, s1_wr_en, s0_wr_en} = 4'b0;
    frame_start = 1'b0; mode_req_valid = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    frame_start = 1'b0; mode_req_valid = 1'b0; mode_req = 2'd0;
    {s3_wr_en, s2_wr_en, s1_wr_en, s0_wr_en} = 4'b0;
    s0_data = '0; s2_data = '0; s3_data = '0; s1_y = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_wr_en", 16'(isp_wr_en), 16'd0);
    chk("rst_rgb", isp_rgb565, 16'h0000);
    chk("rst_done", 16'(frame_done), 16'd0);
    chk("rst_mode", 16'(cur_mode), 16'd3);
    chk("rst_busy", 16'(switch_busy), 16'd1);
    sys_rst = 1'b0;

    // Resync, then a full morph frame with bypass noise alongside.
    step(4'b0000, 16'h0, 1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(4'b1001, 16'hF800, 1'b0, 1'b0, 2'd0, 1'b1, 16'hF800, i == 7);
      if (i == 0) chk("busy_after_first", 16'(switch_busy), 16'd0);
    end

    // PEND then cancel by re-requesting the current mode.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h0100 + 16'(i);
      step(4'b1000, d, 1'b0, i == 1 || i == 3, (i == 1) ? 2'd2 : 2'd3, 1'b1, d, i == 7);
      if (i == 1) chk("pend_busy", 16'(switch_busy), 16'd1);
      if (i == 3) chk("cancel_busy", 16'(switch_busy), 16'd0);
    end
    chk("cancel_mode", 16'(cur_mode), 16'd3);

    // frame_start on the last pixel: no frame_done, counter restarts at 1.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h0200 + 16'(i);
      step(4'b1000, d, i == 7, 1'b0, 2'd0, 1'b1, d, 1'b0);
    end
    chk("fs_last_busy", 16'(switch_busy), 16'd0);
    for (int i = 1; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h0300 + 16'(i);
      step(4'b1000, d, 1'b0, 1'b0, 2'd0, 1'b1, d, i == 7);
    end

    // Switch to grey at pixel 2; the current frame completes first.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h0400 + 16'(i);
      step(4'b1000, d, 1'b0, i == 2, 2'd1, 1'b1, d, i == 7);
      if (i == 6) chk("pend_mode_hold", 16'(cur_mode), 16'd3);
    end
    chk("switched_mode", 16'(cur_mode), 16'd1);
    chk("switched_busy", 16'(switch_busy), 16'd1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, (i < 6) ? 16'h00FF : 16'h0084, 1'b0, 1'b0, 2'd0,
           1'b1, (i < 6) ? 16'hFFFF : 16'h8430, i == 7);
      if (i == 0) chk("grey_busy", 16'(switch_busy), 16'd0);
    end

    // Asynchronous reset while a pixel is on the output.
    step(4'b0010, 16'h00FF, 1'b0, 1'b0, 2'd0, 1'b1, 16'hFFFF, 1'b0);
    step(4'b0010, 16'h00FF, 1'b0, 1'b0, 2'd0, 1'b1, 16'hFFFF, 1'b0);
    step(4'b0010, 16'h00FF, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    chk("pre_rst_wr_en", 16'(isp_wr_en), 16'd1);
    sys_rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 16'(isp_wr_en), 16'd0);
    chk("async_rst_mode", 16'(cur_mode), 16'd3);
    chk("async_rst_busy", 16'(switch_busy), 16'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // No resync: morph stream enters at pixel 3 and must wait for the wrap.
    step(4'b0000, 16'h0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    chk("align_req_mode", 16'(cur_mode), 16'd0);
    for (int i = 0; i < 3; i++) step(4'b1000, 16'hAAAA, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    step(4'b0000, 16'h0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 1'b0);
    chk("align_req_mode3", 16'(cur_mode), 16'd3);
    for (int i = 3; i < 8; i++) step(4'b1000, 16'hBBBB, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    chk("midframe_busy", 16'(switch_busy), 16'd1);
    // Request coincident with a first pixel wins: mode changes, nothing forwarded.
    step(4'b1001, 16'hCCCC, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 1'b0);
    chk("first_req_mode", 16'(cur_mode), 16'd0);
    chk("first_req_busy", 16'(switch_busy), 16'd1);
    step(4'b0000, 16'h0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i < 8; i++) step(4'b1000, 16'hDDDD, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'h0500 + 16'(i);
      step(4'b1000, d, 1'b0, 1'b0, 2'd0, 1'b1, d, i == 7);
    end
    chk("final_mode", 16'(cur_mode), 16'd3);
    chk("final_busy", 16'(switch_busy), 16'd0);
    step(4'b0000, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 1'b0);
    chk("rgb_hold", isp_rgb565, 16'h0507);
    chk("sb_empty", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
